// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//
// Purpose: groups the signals exchanged between the VGA timing generator and
// the drawing pipeline: the generator publishes the current pixel coordinate
// and the drawing logic answers with a colour some enabled cycles later.
//
// Parameters:
//   X_W      width of the column coordinate
//   Y_W      width of the line coordinate
//   COLOR_W  bits per colour channel
//
// Signals:
//   pxl_x, pxl_y                  current coordinate (valid when pxl_active)
//   pxl_active                    coordinate lies inside the visible area
//   red_in, green_in, blue_in     colour returned by the drawing logic
//
// Modports:
//   master  timing generator side (drives coordinates, receives colour)
//   slave   drawing logic side (receives coordinates, drives colour)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 4
);
    logic [X_W-1:0]     pxl_x;
    logic [Y_W-1:0]     pxl_y;
    logic               pxl_active;
    logic [COLOR_W-1:0] red_in;
    logic [COLOR_W-1:0] green_in;
    logic [COLOR_W-1:0] blue_in;

    modport master (
        output pxl_x,
        output pxl_y,
        output pxl_active,
        input  red_in,
        input  green_in,
        input  blue_in
    );

    modport slave (
        input  pxl_x,
        input  pxl_y,
        input  pxl_active,
        output red_in,
        output green_in,
        output blue_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose: parametrised VGA raster timing generator and pixel output stage.
// Horizontal/vertical counters advance on the pixel-clock enable; the current
// coordinate is handed to the drawing logic, and sync/blank are delayed by the
// drawing latency so the returned colour lines up with them at the pins.
//
// Optional feature (macro VGA_FRAME_CNT_EN): adds a 16-bit frame counter
// output that increments on every frame_start pulse.
//
// Ports:
//   clk          system clock
//   resetN       synchronous active-low reset
//   pix_en       pixel-clock enable; nothing advances while it is low
//   draw         coordinate/colour exchange with the drawing logic (master)
//   hsync/vsync  registered sync outputs, polarity set by HS_POL/VS_POL
//   red/green/blue  registered colour, forced to zero outside visible area
//   line_start   one-clk pulse when the column counter wraps to 0
//   frame_start  one-clk pulse when both counters wrap to 0
//   frame_cnt    (VGA_FRAME_CNT_EN only) frames since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = 4,
    parameter int PIPE_DLY = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               pix_en,
    vga_timing_gen_if.master   draw,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int X_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Pin level that means "sync asserted"
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_last;
    logic           v_last;

    // Stage 0 flags; hs0/vs0 mean "asserted", independent of pin polarity
    logic active0;
    logic hs0;
    logic vs0;

    // The same flags after the drawing-latency delay line
    logic active_d;
    logic hs_d;
    logic vs_d;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Raster counters: column advances every enabled cycle, line advances
    // when the column wraps, and the frame wraps when both are at their end.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end
    end

    // Stage 0 decode straight from the counters
    always_comb begin
        active0 = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hs0     = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
        vs0     = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
    end

    // Coordinates are forced to zero in blanking so the drawing logic never
    // sees an out-of-range column or line.
    assign draw.pxl_active = active0;
    assign draw.pxl_x      = active0 ? h_cnt[X_W-1:0] : '0;
    assign draw.pxl_y      = active0 ? v_cnt[Y_W-1:0] : '0;

    // Delay line matching the drawing latency; with zero latency the stage 0
    // flags feed the output register directly.
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign active_d = active0;
            assign hs_d     = hs0;
            assign vs_d     = vs0;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] act_pipe;
            logic [PIPE_DLY-1:0] hs_pipe;
            logic [PIPE_DLY-1:0] vs_pipe;

            // Shift on pix_en only; reset clears to "blank, no sync"
            always_ff @(posedge clk) begin
                if (!resetN) begin
                    act_pipe <= '0;
                    hs_pipe  <= '0;
                    vs_pipe  <= '0;
                end else if (pix_en) begin
                    act_pipe[0] <= active0;
                    hs_pipe[0]  <= hs0;
                    vs_pipe[0]  <= vs0;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        act_pipe[i] <= act_pipe[i-1];
                        hs_pipe[i]  <= hs_pipe[i-1];
                        vs_pipe[i]  <= vs_pipe[i-1];
                    end
                end
            end

            assign active_d = act_pipe[PIPE_DLY-1];
            assign hs_d     = hs_pipe[PIPE_DLY-1];
            assign vs_d     = vs_pipe[PIPE_DLY-1];
        end
    endgenerate

    // Output register: applies sync polarity and blanks the colour outside
    // the delayed visible window regardless of what the drawing logic sends.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pix_en) begin
            hsync <= hs_d ? HS_ON : ~HS_ON;
            vsync <= vs_d ? VS_ON : ~VS_ON;
            red   <= active_d ? draw.red_in   : '0;
            green <= active_d ? draw.green_in : '0;
            blue  <= active_d ? draw.blue_in  : '0;
        end
    end

    // Wrap pulses: high for the single clk following the wrapping edge, so
    // they line up with coordinate (0, y) / (0, 0), not with the pins.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && h_last;
            frame_start <= pix_en && h_last && v_last;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter updates on the same edge that raises frame_start
    always_ff @(posedge clk) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (pix_en && h_last && v_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
